// File: rtl/insn_sequencer_pkg.sv
// Shared state encoding and reset constants for the multicycle instruction sequencer.
package insn_sequencer_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    TRAP    = 3'd5
  } seq_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [31:0] BASEADDR_DEFAULT = 32'h0100_0000;

endpackage

// File: rtl/insn_sequencer_pc_unit.sv
// Program counter: resets to the boot address, advances by 4 or loads a halfword-aligned target.
module insn_sequencer_pc_unit
  import insn_sequencer_pkg::*;
#(
  parameter int unsigned       AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(BASEADDR_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_advance,
  input  logic              i_pcsel,
  input  logic [AWIDTH-1:0] i_target,
  output logic [AWIDTH-1:0] o_pc
);

  logic [AWIDTH-1:0] r_pc;
  logic [AWIDTH-1:0] w_next_pc;

  assign w_next_pc = i_pcsel ? (i_target & ~AWIDTH'(1)) : (r_pc + AWIDTH'(4));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= BASEADDR;
    end else if (i_advance) begin
      r_pc <= w_next_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/insn_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RV32I core.
// Holds the instruction register and the decode controls latched for the rest of the instruction.
module insn_sequencer
  import insn_sequencer_pkg::*;
#(
  parameter int unsigned       DWIDTH   = 32,
  parameter int unsigned       AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(BASEADDR_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_rdy_i,
  input  logic [DWIDTH-1:0] imem_data_i,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o,
  input  logic              illegal_i,
  input  logic              pcsel_i,
  input  logic              regwren_i,
  input  logic              memren_i,
  input  logic              memwren_i,
  input  logic [AWIDTH-1:0] target_i,
  input  logic              dmem_rdy_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic              rf_we_o,
  output logic              retire_o,
  output logic              trap_o,
  output logic [2:0]        state_o
);

  seq_state_e        r_state;
  seq_state_e        w_next_state;
  logic              w_complete;
  logic [DWIDTH-1:0] r_insn;
  logic              r_pcsel_q;
  logic              r_regwren_q;
  logic              r_memren_q;
  logic              r_memwren_q;
  logic [AWIDTH-1:0] r_target_q;
  logic [AWIDTH-1:0] w_target;
  logic [AWIDTH-1:0] w_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_complete   = 1'b0;
    case (r_state)
      FETCH: begin
        if (imem_rdy_i) w_next_state = DECODE;
      end
      DECODE: begin
        if (illegal_i || (memren_i && memwren_i)) w_next_state = TRAP;
        else                                      w_next_state = EXECUTE;
      end
      EXECUTE: begin
        if (r_memren_q || r_memwren_q) begin
          w_next_state = MEM;
        end else if (r_regwren_q) begin
          w_next_state = WB;
        end else begin
          w_next_state = FETCH;
          w_complete   = 1'b1;
        end
      end
      MEM: begin
        if (dmem_rdy_i) begin
          if (r_memren_q) begin
            w_next_state = WB;
          end else begin
            w_next_state = FETCH;
            w_complete   = 1'b1;
          end
        end
      end
      WB: begin
        w_next_state = FETCH;
        w_complete   = 1'b1;
      end
      TRAP:    w_next_state = TRAP;
      default: w_next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_insn      <= DWIDTH'(NOP_INSN);
      r_pcsel_q   <= 1'b0;
      r_regwren_q <= 1'b0;
      r_memren_q  <= 1'b0;
      r_memwren_q <= 1'b0;
      r_target_q  <= '0;
    end else begin
      if (r_state == FETCH && imem_rdy_i) r_insn <= imem_data_i;
      if (r_state == DECODE) begin
        r_pcsel_q   <= pcsel_i;
        r_regwren_q <= regwren_i;
        r_memren_q  <= memren_i;
        r_memwren_q <= memwren_i;
      end
      if (r_state == EXECUTE) r_target_q <= target_i;
    end
  end

  // An instruction retiring straight out of EXECUTE has not latched its target yet.
  assign w_target = (r_state == EXECUTE) ? target_i : r_target_q;

  insn_sequencer_pc_unit #(
    .AWIDTH  (AWIDTH),
    .BASEADDR(BASEADDR)
  ) u_pc_unit (
    .clk      (clk),
    .rst      (rst),
    .i_advance(w_complete),
    .i_pcsel  (r_pcsel_q),
    .i_target (w_target),
    .o_pc     (w_pc)
  );

  assign imem_req_o  = (r_state == FETCH);
  assign imem_addr_o = w_pc;
  assign pc_o        = w_pc;
  assign insn_o      = r_insn;
  assign dmem_req_o  = (r_state == MEM);
  assign dmem_we_o   = (r_state == MEM) && r_memwren_q;
  assign rf_we_o     = (r_state == WB);
  assign retire_o    = w_complete;
  assign trap_o      = (r_state == TRAP);
  assign state_o     = r_state;

endmodule

// File: tb/tb_insn_sequencer.sv
// Bench for insn_sequencer: a random instruction stream scored against a transaction-level model,
// followed by directed trap and reset-during-data-access scenarios.
module tb_insn_sequencer;

  localparam logic [31:0] BASE    = 32'h0100_0000;
  localparam logic [31:0] ST_TRAP = 32'd5;
  localparam int          NRAND   = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_rdy_i;
  logic [31:0] imem_data_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] insn_o;
  logic [31:0] pc_o;
  logic        illegal_i;
  logic        pcsel_i;
  logic        regwren_i;
  logic        memren_i;
  logic        memwren_i;
  logic [31:0] target_i;
  logic        dmem_rdy_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        rf_we_o;
  logic        retire_o;
  logic        trap_o;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  insn_sequencer #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .imem_rdy_i(imem_rdy_i), .imem_data_i(imem_data_i), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .insn_o(insn_o), .pc_o(pc_o),
    .illegal_i(illegal_i), .pcsel_i(pcsel_i), .regwren_i(regwren_i),
    .memren_i(memren_i), .memwren_i(memwren_i), .target_i(target_i),
    .dmem_rdy_i(dmem_rdy_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .rf_we_o(rf_we_o), .retire_o(retire_o), .trap_o(trap_o), .state_o(state_o)
  );

  // memSel: 0 = no memory access, 1 = load, 2 = store
  typedef struct {
    logic [31:0] insn;
    int          fd;
    int          md;
    int          memSel;
    logic        regwren;
    logic        pcsel;
    logic [31:0] target;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    int          cycles;
    int          rfw;
    int          memReq;
    int          memWe;
  } exp_t;

  exp_t        sbQ[$];
  stim_t       directed[$];
  logic [31:0] modelPc;
  int          nChecks = 0;
  int          nPass   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    nChecks++;
    if (act === want) nPass++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
  endtask

  task automatic addDirected(input logic [31:0] insn, input int fd, input int md, input int memSel,
                             input logic regwren, input logic pcsel, input logic [31:0] target);
    stim_t s;
    s = '{insn, fd, md, memSel, regwren, pcsel, target};
    directed.push_back(s);
  endtask

  // Reference model: what an instruction should look like from the outside, by rule.
  function automatic exp_t predict(input stim_t s, input logic [31:0] pc);
    exp_t e;
    int   wb;
    wb       = (s.memSel == 1) ? 1 : (s.memSel == 2) ? 0 : int'(s.regwren);
    e.pc     = pc;
    e.insn   = s.insn;
    e.memReq = (s.memSel != 0) ? s.md + 1 : 0;
    e.memWe  = (s.memSel == 2) ? s.md + 1 : 0;
    e.rfw    = wb;
    e.cycles = (s.fd + 1) + 1 + 1 + e.memReq + wb;
    return e;
  endfunction

  function automatic logic [31:0] nextPc(input stim_t s, input logic [31:0] pc);
    return s.pcsel ? (s.target & 32'hFFFF_FFFE) : pc + 32'd4;
  endfunction

  function automatic stim_t genStim(input int idx);
    stim_t s;
    if (idx < directed.size()) return directed[idx];
    s.insn    = $urandom;
    s.fd      = int'($urandom_range(0, 2));
    s.md      = int'($urandom_range(0, 3));
    s.memSel  = int'($urandom_range(0, 2));
    s.regwren = 1'($urandom);
    s.pcsel   = ($urandom_range(0, 3) == 0);
    s.target  = $urandom;
    return s;
  endfunction

  // Acts as instruction memory, decoder and data memory; controls are only meaningful in
  // DECODE and the target only in EXECUTE, so everything else is driven with noise.
  task automatic applyStimulus(input int nInsn);
    int    issued = 0;
    int    phase  = 3;
    int    fWait  = 0;
    int    mWait  = 0;
    int    budget = 0;
    bit    done   = 0;
    stim_t cur;
    cur = genStim(0);
    while (!done && budget < 4000) begin
      illegal_i = 1'($urandom);
      pcsel_i   = 1'($urandom);
      regwren_i = 1'($urandom);
      memren_i  = 1'($urandom);
      memwren_i = 1'($urandom);
      target_i  = $urandom;
      if (phase == 1) begin
        illegal_i = 1'b0;
        pcsel_i   = cur.pcsel;
        regwren_i = cur.regwren;
        memren_i  = (cur.memSel == 1);
        memwren_i = (cur.memSel == 2);
        phase     = 2;
      end else if (phase == 2) begin
        target_i = cur.target;
        phase    = 3;
      end
      imem_rdy_i  = 1'($urandom);
      imem_data_i = $urandom;
      if (imem_req_o && phase == 3) begin
        if (issued == nInsn) begin
          done       = 1;
          imem_rdy_i = 1'b0;
        end else begin
          cur = genStim(issued);
          sbQ.push_back(predict(cur, modelPc));
          modelPc = nextPc(cur, modelPc);
          issued++;
          fWait = cur.fd;
          mWait = cur.md;
          phase = 0;
        end
      end
      if (imem_req_o && phase == 0) begin
        if (fWait > 0) begin
          imem_rdy_i = 1'b0;
          fWait--;
        end else begin
          imem_rdy_i  = 1'b1;
          imem_data_i = cur.insn;
          phase       = 1;
        end
      end
      dmem_rdy_i = 1'($urandom);
      if (dmem_req_o) begin
        if (mWait > 0) begin
          dmem_rdy_i = 1'b0;
          mWait--;
        end else begin
          dmem_rdy_i = 1'b1;
        end
      end
      if (!done) begin
        @(negedge clk);
        budget++;
      end
    end
    checkOutput("drvDone", 32'(done), 32'd1);
  endtask

  // Scoreboard monitor: accumulates per-instruction activity and scores it at each retire.
  initial begin : monitor
    int   cyc;
    int   rfw;
    int   memReq;
    int   memWe;
    exp_t e;
    cyc = 0; rfw = 0; memReq = 0; memWe = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        cyc = 0; rfw = 0; memReq = 0; memWe = 0;
      end else begin
        cyc++;
        if (rf_we_o)    rfw++;
        if (dmem_req_o) memReq++;
        if (dmem_we_o)  memWe++;
        if (retire_o) begin
          checkOutput("retireExpected", 32'(sbQ.size() > 0), 32'd1);
          if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("retirePc", pc_o, e.pc);
            checkOutput("retireInsn", insn_o, e.insn);
            checkOutput("retireCycles", 32'(cyc), 32'(e.cycles));
            checkOutput("rfWrites", 32'(rfw), 32'(e.rfw));
            checkOutput("dmemReqCycles", 32'(memReq), 32'(e.memReq));
            checkOutput("dmemWeCycles", 32'(memWe), 32'(e.memWe));
          end
          cyc = 0; rfw = 0; memReq = 0; memWe = 0;
        end
      end
    end
  end

  task automatic trapTest(input bit viaBothMem);
    int reqs    = 0;
    int strobes = 0;
    @(negedge clk);
    rst = 1'b1; imem_rdy_i = 1'b0; dmem_rdy_i = 1'b0;
    @(negedge clk);
    rst = 1'b0; imem_rdy_i = 1'b1; imem_data_i = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_rdy_i = 1'b0;
    illegal_i  = !viaBothMem;
    memren_i   = viaBothMem;
    memwren_i  = viaBothMem;
    pcsel_i    = 1'b0;
    regwren_i  = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("trapFlag", 32'(trap_o), 32'd1);
    checkOutput("trapState", 32'(state_o), ST_TRAP);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      imem_rdy_i = 1'($urandom);
      dmem_rdy_i = 1'($urandom);
      illegal_i  = 1'($urandom);
      #1;
      if (imem_req_o) reqs++;
      if (dmem_req_o || dmem_we_o || rf_we_o || retire_o) strobes++;
    end
    checkOutput("trapNoFetch", 32'(reqs), 32'd0);
    checkOutput("trapNoStrobes", 32'(strobes), 32'd0);
    checkOutput("trapPcHold", pc_o, BASE);
    checkOutput("trapInsnHold", insn_o, 32'hFFFF_FFFF);
    checkOutput("trapSticky", 32'(trap_o), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("trapCleared", 32'(trap_o), 32'd0);
    checkOutput("trapResetState", 32'(state_o), 32'd0);
  endtask

  task automatic midMemTest();
    @(negedge clk);
    rst = 1'b1; imem_rdy_i = 1'b0; dmem_rdy_i = 1'b0;
    @(negedge clk);
    rst = 1'b0; imem_rdy_i = 1'b1; imem_data_i = 32'h0000_2103;
    @(negedge clk);
    imem_rdy_i = 1'b0; illegal_i = 1'b0; pcsel_i = 1'b0;
    regwren_i  = 1'b1; memren_i  = 1'b1; memwren_i = 1'b0;
    @(negedge clk);
    target_i = $urandom;
    @(negedge clk);
    dmem_rdy_i = 1'b0;
    #1;
    checkOutput("loadReq", 32'(dmem_req_o), 32'd1);
    checkOutput("loadWe", 32'(dmem_we_o), 32'd0);
    @(negedge clk);
    dmem_rdy_i = 1'b1;
    rst        = 1'b1;
    #1;
    checkOutput("rstDropsReq", 32'(dmem_req_o), 32'd0);
    checkOutput("rstNoRetire", 32'(retire_o), 32'd0);
    checkOutput("rstFetchReq", 32'(imem_req_o), 32'd1);
    checkOutput("rstFetchAddr", imem_addr_o, BASE);
    @(negedge clk);
    rst = 1'b0; dmem_rdy_i = 1'b0; imem_rdy_i = 1'b0;
    #1;
    checkOutput("postRstReq", 32'(imem_req_o), 32'd1);
    checkOutput("postRstAddr", imem_addr_o, BASE);
    checkOutput("postRstNoRetire", 32'(retire_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    imem_rdy_i = 1'b0; imem_data_i = '0; illegal_i = 1'b0; pcsel_i = 1'b0;
    regwren_i  = 1'b0; memren_i    = 1'b0; memwren_i = 1'b0; target_i = '0;
    dmem_rdy_i = 1'b0;
    modelPc    = BASE;

    addDirected(32'h0010_0093, 0, 0, 0, 1'b1, 1'b0, 32'h0);          // addi
    addDirected(32'h0000_2103, 0, 3, 1, 1'b1, 1'b0, 32'h0);          // lw, slow data memory
    addDirected(32'h0020_2023, 0, 0, 2, 1'b0, 1'b0, 32'h0);          // sw
    addDirected(32'h0080_00EF, 0, 0, 0, 1'b1, 1'b1, 32'h0100_0101);  // jal, odd target
    addDirected(32'h0000_0063, 0, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFD);  // branch to top of memory
    addDirected(32'h0010_0093, 0, 0, 0, 1'b1, 1'b0, 32'h0);          // addi at 0xFFFF_FFFC wraps
    addDirected(32'h0020_0113, 2, 0, 0, 1'b1, 1'b0, 32'h0);          // addi, slow fetch

    repeat (2) @(negedge clk);
    #1;
    checkOutput("resetPc", pc_o, BASE);
    checkOutput("resetAddr", imem_addr_o, BASE);
    checkOutput("resetInsn", insn_o, 32'h0000_0013);
    checkOutput("resetState", 32'(state_o), 32'd0);
    checkOutput("resetTrap", 32'(trap_o), 32'd0);
    checkOutput("resetStrobes", 32'({rf_we_o, retire_o, dmem_req_o, dmem_we_o}), 32'd0);
    checkOutput("resetFetchReq", 32'(imem_req_o), 32'd1);

    @(negedge clk);
    rst = 1'b0;
    applyStimulus(directed.size() + NRAND);
    checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);

    trapTest(1'b0);
    trapTest(1'b1);
    midMemTest();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
